// File: rtl/div3_pkg.sv
// Shared types and default sizing for the sequential divide-by-3 controller.
package div3_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int CHUNK_W_DEF = 4;
    localparam int STEPS       = DATA_W_DEF / CHUNK_W_DEF;
    localparam int REM_W       = 2;
    localparam int CNT_W       = $clog2(STEPS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/div3_step.sv
// One constant-division step: {rem, chunk} / 3 as a (CHUNK_W+2)-input LUT.
module div3_step
    import div3_pkg::*;
#(
    parameter int CHUNK_W = CHUNK_W_DEF
) (
    input  logic [REM_W-1:0]   rem,
    input  logic [CHUNK_W-1:0] chunk,
    output logic [CHUNK_W-1:0] digit,
    output logic [REM_W-1:0]   rem_next
);

    localparam int V_W = CHUNK_W + REM_W;
    localparam logic [V_W-1:0] DIVISOR = V_W'(3);

    logic [V_W-1:0] v;
    logic [V_W-1:0] q_full;
    logic [V_W-1:0] r_full;

    always_comb begin
        v        = {rem, chunk};
        q_full   = v / DIVISOR;
        r_full   = v % DIVISOR;
        digit    = q_full[CHUNK_W-1:0];
        rem_next = r_full[REM_W-1:0];
        // A legal remainder (< 3) keeps the digit inside CHUNK_W bits.
        assert (q_full[V_W-1:CHUNK_W] == '0 && r_full[V_W-1:REM_W] == '0);
    end

endmodule

// File: rtl/div3_seq_ctrl.sv
// Sequential divide-by-3: walks the dividend MSB-first, one CHUNK_W chunk per cycle.
module div3_seq_ctrl
    import div3_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CHUNK_W = CHUNK_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_quot,
    output logic [REM_W-1:0]  out_rem,
    output logic              busy
);

    localparam int N_STEPS = DATA_W / CHUNK_W;
    localparam int N_CNT_W = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam logic [N_CNT_W-1:0] LAST_STEP = N_CNT_W'(N_STEPS - 1);

    state_t             state_q;
    state_t             state_d;
    logic [N_CNT_W-1:0] cnt;
    logic [REM_W-1:0]   rem;
    logic [DATA_W-1:0]  dvd;
    logic [DATA_W-1:0]  quo;
    logic [DATA_W-1:0]  quo_next;
    logic [CHUNK_W-1:0] digit;
    logic [REM_W-1:0]   rem_next;
    logic               accept;
    logic               last_step;

    // in_ready is held low during reset even though the state already reads IDLE.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign last_step = (state_q == RUN) && (cnt == LAST_STEP);
    assign quo_next  = {quo[DATA_W-CHUNK_W-1:0], digit};

    div3_step #(
        .CHUNK_W (CHUNK_W)
    ) u_step (
        .rem      (rem),
        .chunk    (dvd[DATA_W-1 -: CHUNK_W]),
        .digit    (digit),
        .rem_next (rem_next)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (cnt == LAST_STEP) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            out_quot  <= '0;
            out_rem   <= '0;
            out_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt <= '0;
                rem <= '0;
            end else if (state_q == RUN) begin
                cnt <= cnt + 1'b1;
                rem <= rem_next;
            end
            if (last_step) begin
                out_quot  <= quo_next;
                out_rem   <= rem_next;
                out_valid <= 1'b1;
            end else if ((state_q == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Shift registers are pure datapath; an aborted job leaves them stale but unused.
    always_ff @(posedge clk) begin
        if (accept) begin
            dvd <= in_data;
            quo <= '0;
        end else if (state_q == RUN) begin
            dvd <= dvd << CHUNK_W;
            quo <= quo_next;
        end
    end

endmodule
